// File: rtl/display_channel_sequencer.sv
// Display channel sequencer: selects one of NUM_CH display channels, either manually or by
// timed auto-scan, and registers the chosen value and decimal points for the display driver.
module display_channel_sequencer #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 16,
  parameter int DP_W         = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH*DP_W-1:0]   ch_dp,
  input  logic                     auto_mode,
  input  logic [SEL_W-1:0]         manual_sel,
  input  logic                     step,
  input  logic                     hold,
  input  logic                     update_tick,
  output logic [DATA_W-1:0]        mux_out,
  output logic [DP_W-1:0]          decimal_point,
  output logic [SEL_W-1:0]         active_ch,
  output logic                     out_valid
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);

  logic [CNT_W-1:0]  dwellCnt;
  logic [CNT_W-1:0]  nextCnt;
  logic [SEL_W-1:0]  nextCh;
  logic [SEL_W-1:0]  advanceCh;
  logic              chChanged;
  logic              selInRange;
  logic              dwellExpired;
  logic [DATA_W-1:0] selData;
  logic [DP_W-1:0]   selDp;

  assign advanceCh    = (active_ch == SEL_W'(NUM_CH - 1)) ? '0 : active_ch + SEL_W'(1);
  assign selInRange   = ({1'b0, manual_sel} < (SEL_W + 1)'(NUM_CH));
  assign dwellExpired = (dwellCnt == CNT_W'(DWELL_CYCLES - 1));

  // Step and dwell expiry both collapse into a single advance; manual mode pins the counter
  // at zero so a switch to auto always starts a fresh dwell.
  always_comb begin
    nextCh  = active_ch;
    nextCnt = dwellCnt;
    if (!hold) begin
      if (!auto_mode) begin
        nextCnt = '0;
        if (selInRange) begin
          nextCh = manual_sel;
        end
      end else if (step || dwellExpired) begin
        nextCnt = '0;
        nextCh  = advanceCh;
      end else begin
        nextCnt = dwellCnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    selData = '0;
    selDp   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_ch == SEL_W'(i)) begin
        selData = ch_data[i*DATA_W +: DATA_W];
        selDp   = ch_dp[i*DP_W +: DP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_ch <= '0;
      dwellCnt  <= '0;
      chChanged <= 1'b0;
    end else begin
      active_ch <= nextCh;
      dwellCnt  <= nextCnt;
      chChanged <= (nextCh != active_ch);
    end
  end

  // A channel change is pending for one cycle only; if hold masks it, the next tick refreshes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_out       <= '0;
      decimal_point <= '0;
      out_valid     <= 1'b0;
    end else if (!hold && (update_tick || chChanged)) begin
      mux_out       <= selData;
      decimal_point <= selDp;
      out_valid     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_channel_sequencer.sv
// Randomized scoreboard bench for display_channel_sequencer: a queue-based reference model
// predicts the post-edge outputs each cycle and a negedge monitor compares them.
module tb_display_channel_sequencer;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int DP_W   = 4;
  localparam int DWELL  = 4;
  localparam int SEL_W  = 2;
  localparam int CYCLES = 3000;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] chData;
  logic [NUM_CH*DP_W-1:0]   chDp;
  logic                     autoMode;
  logic [SEL_W-1:0]         manualSel;
  logic                     step;
  logic                     hold;
  logic                     updateTick;
  logic [DATA_W-1:0]        muxOut;
  logic [DP_W-1:0]          decimalPoint;
  logic [SEL_W-1:0]         activeCh;
  logic                     outValid;

  always #5 clk = ~clk;

  display_channel_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DP_W(DP_W), .DWELL_CYCLES(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .ch_data(chData), .ch_dp(chDp),
    .auto_mode(autoMode), .manual_sel(manualSel), .step(step), .hold(hold),
    .update_tick(updateTick), .mux_out(muxOut), .decimal_point(decimalPoint),
    .active_ch(activeCh), .out_valid(outValid)
  );

  typedef struct packed {
    logic [SEL_W-1:0]  ch;
    logic [DATA_W-1:0] data;
    logic [DP_W-1:0]   dp;
    logic              valid;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;

  logic [DATA_W-1:0] chVal[NUM_CH];
  logic [DP_W-1:0]   chDpv[NUM_CH];

  int                mCh;
  int                mCnt;
  bit                mChanged;
  logic [DATA_W-1:0] mOut;
  logic [DP_W-1:0]   mDp;
  bit                mValid;

  task automatic packInputs();
    for (int i = 0; i < NUM_CH; i++) begin
      chData[i*DATA_W +: DATA_W] = chVal[i];
      chDp[i*DP_W +: DP_W]       = chDpv[i];
    end
  endtask

  task automatic modelReset();
    mCh = 0; mCnt = 0; mChanged = 0; mOut = '0; mDp = '0; mValid = 0;
  endtask

  function automatic exp_t modelExp();
    exp_t e;
    e.ch    = SEL_W'(mCh);
    e.data  = mOut;
    e.dp    = mDp;
    e.valid = mValid;
    return e;
  endfunction

  // One rising edge of the reference behaviour, using the inputs present at that edge.
  task automatic modelEdge();
    int prevCh = mCh;
    if (!hold && (updateTick || mChanged)) begin
      mOut   = chVal[mCh];
      mDp    = chDpv[mCh];
      mValid = 1;
    end
    if (!hold) begin
      if (!autoMode) begin
        mCnt = 0;
        if (int'(manualSel) < NUM_CH) mCh = int'(manualSel);
      end else if (step || mCnt == DWELL - 1) begin
        mCnt = 0;
        mCh  = (mCh + 1) % NUM_CH;
      end else begin
        mCnt = mCnt + 1;
      end
    end
    mChanged = (mCh != prevCh);
  endtask

  task automatic applyStimulus(input int cyc);
    if (cyc < 4) begin
      autoMode = 0; manualSel = 2'd1; step = 0; hold = 0; updateTick = 0;
    end else if (cyc < 30) begin
      autoMode = 1; step = 0; hold = 0; updateTick = 0;
    end else begin
      if ($urandom_range(15) == 0) autoMode = ~autoMode;
      if ($urandom_range(3) == 0) manualSel = SEL_W'($urandom_range(3));
      if ($urandom_range(9) == 0) hold = ~hold;
      step       = ($urandom_range(7) == 0);
      updateTick = ($urandom_range(3) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(3) == 0) begin
          chVal[i] = DATA_W'($urandom);
          chDpv[i] = DP_W'($urandom);
        end
      end
    end
    packInputs();
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({activeCh, muxOut, decimalPoint, outValid} === e) begin
      passes++;
    end else begin
      $display("[TB] FAIL outputs t=%0t: active_ch=%0d mux_out=%h dp=%b valid=%b, required active_ch=%0d mux_out=%h dp=%b valid=%b",
               $time, activeCh, muxOut, decimalPoint, outValid, e.ch, e.data, e.dp, e.valid);
    end
  endtask

  // Monitor: compare the DUT against the oldest prediction, half a cycle after each edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    bit pulseReset;
    reset = 1'b1;
    autoMode = 0; manualSel = '0; step = 0; hold = 0; updateTick = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      chVal[i] = DATA_W'(16'h1111 * (i + 1));
      chDpv[i] = DP_W'(1 << i);
    end
    packInputs();
    modelReset();
    expQ.push_back(modelExp());
    @(negedge clk);
    #2;
    applyStimulus(0);
    reset = 1'b0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      modelEdge();
      pulseReset = (cyc > 40) && ($urandom_range(99) == 0);
      if (pulseReset) begin
        #2;
        reset = 1'b1;
        modelReset();
      end
      expQ.push_back(modelExp());
      #2;
      applyStimulus(cyc);
      if (pulseReset) begin
        @(negedge clk);
        #2;
        reset = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
